// File: rtl/pll_seq_pkg.sv
// -----------------------------------------------------------------------------
// pll_seq_pkg
// Shared definitions for the PLL reset/lock sequencer:
//   - pll_seq_state_t : sequencer state encoding
//   - DEF_*           : default parameter values
//   - cnt_w()         : counter width for a count range 0..n-1 (minimum 1 bit)
// -----------------------------------------------------------------------------
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } pll_seq_state_t;

    localparam int DEF_RST_HOLD     = 16;
    localparam int DEF_LOCK_STABLE  = 1024;
    localparam int DEF_LOCK_TIMEOUT = 65536;
    localparam int DEF_MAX_RETRY    = 3;

    // $clog2(1) is 0, which would give a zero-width counter; keep at least 1 bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_ff2.sv
// -----------------------------------------------------------------------------
// sync_ff2
// Two-flop synchroniser with asynchronous active-low clear.
// Ports:
//   clk   in  destination clock
//   clr_n in  asynchronous clear, active low (both flops go to 0)
//   d     in  asynchronous input
//   q     out synchronised output (2 clk latency)
// -----------------------------------------------------------------------------
module sync_ff2 (
    input  logic clk,
    input  logic clr_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_seq.sv
// -----------------------------------------------------------------------------
// pll_reset_seq
// Reset/lock sequencer for the core PLL. Holds the PLL in reset, waits for a
// stable synchronised lock, then releases the core reset. Loss of lock in RUN
// forces a full relock. Everything runs on refclk.
//
// Build option:
//   PLL_SEQ_RETRY_EN  defined   : lock timeout, bounded retries, FAIL state.
//                     undefined : WAIT_LOCK/STABLE wait indefinitely, fail=0,
//                                 retry_cnt=0, LOCK_TIMEOUT/MAX_RETRY ignored.
//
// Ports:
//   refclk     in  50 MHz reference clock
//   rst_n      in  asynchronous active-low reset
//   pll_locked in  raw PLL lock (asynchronous)
//   relock_req in  single-cycle restart request
//   pll_rst    out PLL reset, active high (HOLD, FAIL)
//   sys_rst_n  out core reset, active low (released only in RUN)
//   ready      out high only in RUN
//   fail       out high only in FAIL
//   retry_cnt  out timeouts in the current sequence (saturating)
//   loss_cnt   out lock losses seen in RUN (saturating at 255)
// -----------------------------------------------------------------------------
module pll_reset_seq
    import pll_seq_pkg::*;
#(
    parameter int RST_HOLD     = DEF_RST_HOLD,
    parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int MAX_RETRY    = DEF_MAX_RETRY
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    localparam int HW = cnt_w(RST_HOLD);
    localparam int SW = cnt_w(LOCK_STABLE);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);
    localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE - 1);

    pll_seq_state_t state, state_nxt;
    logic [HW-1:0]  hold_cnt;
    logic [SW-1:0]  stab_cnt;
    logic           rst_sync;
    logic           lock_s;
    logic           loss_evt;
    logic           retry_clr;
    logic           retry_inc;
    logic           tmo_done;
    logic [3:0]     retry_q;

    // Reset release is synchronised so HOLD counting starts on a clean edge;
    // assertion still clears the flops immediately.
    sync_ff2 u_rst_sync (
        .clk   (refclk),
        .clr_n (rst_n),
        .d     (1'b1),
        .q     (rst_sync)
    );

    sync_ff2 u_lock_sync (
        .clk   (refclk),
        .clr_n (rst_n),
        .d     (pll_locked),
        .q     (lock_s)
    );

    // Next state. Order of tests encodes priority:
    // relock_req > lock loss > STABLE completion > timeout.
    always_comb begin
        state_nxt = state;
        loss_evt  = 1'b0;
        retry_clr = 1'b0;
        retry_inc = 1'b0;
        if (relock_req) begin
            state_nxt = ST_HOLD;
            retry_clr = 1'b1;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (rst_sync && hold_cnt == HOLD_LAST)
                        state_nxt = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (tmo_done) begin
                        if (retry_q < 4'(MAX_RETRY)) begin
                            state_nxt = ST_HOLD;
                            retry_inc = 1'b1;
                        end else begin
                            state_nxt = ST_FAIL;
                        end
                    end else if (lock_s) begin
                        state_nxt = ST_STABLE;
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_nxt = ST_WAIT_LOCK;
                    end else if (stab_cnt == STAB_LAST) begin
                        state_nxt = ST_RUN;
                    end else if (tmo_done) begin
                        if (retry_q < 4'(MAX_RETRY)) begin
                            state_nxt = ST_HOLD;
                            retry_inc = 1'b1;
                        end else begin
                            state_nxt = ST_FAIL;
                        end
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_nxt = ST_HOLD;
                        loss_evt  = 1'b1;
                        retry_clr = 1'b1;
                    end
                end
                ST_FAIL: state_nxt = ST_FAIL;
                default: state_nxt = ST_HOLD;
            endcase
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_HOLD;
            hold_cnt <= '0;
            stab_cnt <= '0;
            loss_cnt <= '0;
        end else begin
            state <= state_nxt;

            // Any (re)entry into HOLD restarts the hold count from 0.
            if (state == ST_HOLD && state_nxt == ST_HOLD && !relock_req)
                hold_cnt <= rst_sync ? hold_cnt + 1'b1 : hold_cnt;
            else
                hold_cnt <= '0;

            // Only consecutive STABLE cycles count.
            if (state == ST_STABLE && state_nxt == ST_STABLE)
                stab_cnt <= stab_cnt + 1'b1;
            else
                stab_cnt <= '0;

            if (loss_evt && loss_cnt != 8'hFF)
                loss_cnt <= loss_cnt + 1'b1;
        end
    end

`ifdef PLL_SEQ_RETRY_EN
    localparam int TW = cnt_w(LOCK_TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(LOCK_TIMEOUT - 1);

    logic [TW-1:0] tmo_cnt;

    assign tmo_done = (tmo_cnt == TMO_LAST);

    // The timer spans WAIT_LOCK and STABLE together and is cleared only on
    // entry from HOLD, so lock chatter cannot stretch the budget. It holds at
    // its terminal value instead of wrapping.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            retry_q <= '0;
        end else begin
            if (state_nxt == ST_WAIT_LOCK || state_nxt == ST_STABLE) begin
                if (state == ST_HOLD)
                    tmo_cnt <= '0;
                else if (!tmo_done)
                    tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end

            if (retry_clr)
                retry_q <= '0;
            else if (retry_inc && retry_q != 4'hF)
                retry_q <= retry_q + 1'b1;
        end
    end

    assign fail      = (state == ST_FAIL);
    assign retry_cnt = retry_q;
`else
    logic unused_cfg;

    assign tmo_done   = 1'b0;
    assign retry_q    = 4'd0;
    assign fail       = 1'b0;
    assign retry_cnt  = 4'd0;
    assign unused_cfg = ^{retry_clr, retry_inc, LOCK_TIMEOUT[0], MAX_RETRY[0]};
`endif

    assign pll_rst   = (state == ST_HOLD) || (state == ST_FAIL);
    assign ready     = (state == ST_RUN);
    assign sys_rst_n = (state == ST_RUN);

endmodule

// File: tb/tb_pll_reset_seq.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_seq
// Directed bench for pll_reset_seq with RST_HOLD=4, LOCK_STABLE=8,
// LOCK_TIMEOUT=64, MAX_RETRY=2. The retry/FAIL section follows
// PLL_SEQ_RETRY_EN; otherwise the indefinite-wait behaviour is checked.
// -----------------------------------------------------------------------------
module tb_pll_reset_seq;

    localparam int RST_HOLD     = 4;
    localparam int LOCK_STABLE  = 8;
    localparam int LOCK_TIMEOUT = 64;
    localparam int MAX_RETRY    = 2;

    logic       refclk;
    logic       rst_n;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;

    int checks = 0;
    int errors = 0;

    pll_reset_seq #(
        .RST_HOLD     (RST_HOLD),
        .LOCK_STABLE  (LOCK_STABLE),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .relock_req (relock_req),
        .pll_rst    (pll_rst),
        .sys_rst_n  (sys_rst_n),
        .ready      (ready),
        .fail       (fail),
        .retry_cnt  (retry_cnt),
        .loss_cnt   (loss_cnt)
    );

    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    initial begin
        int n;
        int rises;
        int lowlen;
        logic prev_rst;

        rst_n      = 1'b0;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_pll_rst",   pll_rst,   1);
        check("rst_sys_rst_n", sys_rst_n, 0);
        check("rst_ready",     ready,     0);
        check("rst_fail",      fail,      0);
        check("rst_retry",     retry_cnt, 0);
        check("rst_loss",      loss_cnt,  0);

        // Power-up: 2 edges of reset-release sync, then RST_HOLD edges of HOLD.
        rst_n = 1'b1;
        n = 0;
        do begin tick(); n++; end while (pll_rst && n < 50);
        check("pwrup_hold_edges", n, RST_HOLD + 2);

        repeat (9) tick();
        check("no_lock_ready", ready, 0);
        check("no_lock_pll_rst", pll_rst, 0);

        // Lock rises: 2 sync edges + LOCK_STABLE in STABLE -> ready after
        // edge E0+LOCK_STABLE+2, i.e. on the 11th tick counting E0.
        pll_locked = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!ready && n < 100);
        check("lock_to_ready_ticks", n, LOCK_STABLE + 3);
        check("run_sys_rst_n", sys_rst_n, 1);
        check("run_pll_rst",   pll_rst,   0);
        check("run_loss",      loss_cnt,  0);

        // Loss of lock in RUN: HOLD on the 3rd edge after the drop.
        repeat (3) tick();
        pll_locked = 1'b0;
        tick();
        tick();
        check("loss_2nd_edge_ready", ready, 1);
        tick();
        check("loss_sys_rst_n", sys_rst_n, 0);
        check("loss_pll_rst",   pll_rst,   1);
        check("loss_cnt_1",     loss_cnt,  1);
        check("loss_retry",     retry_cnt, 0);
        pll_locked = 1'b1;
        n = 0;
        do begin tick(); n++; end while (pll_rst && n < 50);
        check("loss_hold_cycles", n, RST_HOLD);
        // lock_s already high: WAIT_LOCK 1 cycle + LOCK_STABLE in STABLE.
        n = 0;
        do begin tick(); n++; end while (!ready && n < 100);
        check("relock_ready_ticks", n, LOCK_STABLE + 1);
        check("relock_loss_kept", loss_cnt, 1);

        // relock_req from RUN, then a 1-cycle lock glitch at STABLE cycle 5.
        repeat (2) tick();
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        check("relock_pll_rst", pll_rst, 1);
        check("relock_ready",   ready,   0);
        check("relock_loss",    loss_cnt, 1);
        n = 0;
        do begin tick(); n++; end while (pll_rst && n < 50);
        check("relock_hold_cycles", n, RST_HOLD);
        repeat (5) tick();              // into STABLE, 4 cycles counted
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        check("glitch_ready_low", ready, 0);
        // Drop seen by FSM 2 edges later -> WAIT_LOCK, then STABLE again and
        // a full LOCK_STABLE run: 2 + 1 + LOCK_STABLE = 11 ticks.
        n = 0;
        do begin tick(); n++; end while (!ready && n < 100);
        check("glitch_ready_ticks", n, 11);
        check("glitch_retry", retry_cnt, 0);

        // Asynchronous reset while in STABLE.
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        repeat (RST_HOLD + 3) tick();
        check("stable_ready", ready, 0);
        check("stable_pll_rst", pll_rst, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_pll_rst",   pll_rst,   1);
        check("arst_sys_rst_n", sys_rst_n, 0);
        check("arst_ready",     ready,     0);
        check("arst_fail",      fail,      0);
        check("arst_retry",     retry_cnt, 0);
        check("arst_loss",      loss_cnt,  0);

        pll_locked = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;

`ifdef PLL_SEQ_RETRY_EN
        // Lock never arrives: two retries then FAIL, each WAIT lasting exactly
        // LOCK_TIMEOUT cycles.
        rises    = 0;
        lowlen   = 0;
        prev_rst = pll_rst;
        n        = 0;
        while (!fail && n < 2000) begin
            tick();
            n++;
            if (!pll_rst) begin
                lowlen++;
            end else if (!prev_rst) begin
                rises++;
                check("retry_wait_len", lowlen, LOCK_TIMEOUT);
                check("retry_cnt_step", retry_cnt, (rises < 3) ? rises : 2);
                lowlen = 0;
            end
            prev_rst = pll_rst;
        end
        check("retry_rises", rises, 3);
        check("fail_flag",   fail,  1);
        check("fail_pll_rst", pll_rst, 1);
        check("fail_ready",  ready, 0);
        repeat (5) tick();
        check("fail_terminal", fail, 1);

        // relock_req in FAIL coinciding with a lock drop.
        pll_locked = 1'b1;
        repeat (4) tick();
        pll_locked = 1'b0;
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        check("fail_relock_fail",  fail,      0);
        check("fail_relock_retry", retry_cnt, 0);
        check("fail_relock_rst",   pll_rst,   1);
        check("fail_relock_loss",  loss_cnt,  0);
        n = 0;
        do begin tick(); n++; end while (pll_rst && n < 50);
        check("fail_relock_hold", n, RST_HOLD);
`else
        // Without the retry option the sequencer waits for lock indefinitely.
        repeat (200) tick();
        check("noretry_fail",    fail,      0);
        check("noretry_retry",   retry_cnt, 0);
        check("noretry_pll_rst", pll_rst,   0);
        check("noretry_ready",   ready,     0);
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        check("noretry_relock_rst", pll_rst, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
